// File: rtl/usb_rx_crc16_ctrl.sv
// USB receive-path sequencer for the 16-bit serial CRC checker on DATA packets.
// Optional packet statistics counters are built when CRC_RX_STATS_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no packet in progress; bits and eop ignored
// CLEAR   | one-cycle checker clear, length and len_err reset
// SHIFT   | non-stuffed bits forwarded to the checker and counted
// WAIT    | waiting out the checker pipeline before sampling crc_value
// VERDICT | one-cycle crc_ok or crc_err pulse
module usb_rx_crc16_ctrl #(
   parameter int          MAX_BITS  = 8232,
   parameter int          CHECK_LAT = 1,
   parameter logic [15:0] RESIDUAL  = 16'h800D
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        sop,
   input  logic        rx_bit_valid,
   input  logic        rx_bit,
   input  logic        bit_stuff_st,
   input  logic        eop,
   input  logic [15:0] crc_value,
   output logic        crc_clear,
   output logic        crc_shift_enable,
   output logic        crc_serial_in,
   output logic        crc_eop,
   output logic        crc_ok,
   output logic        crc_err,
   output logic        len_err,
   output logic [13:0] bit_count,
   output logic        busy,
   output logic [7:0]  good_pkts,
   output logic [7:0]  bad_pkts
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_WAIT,
      S_VERDICT
   } state_t;

   localparam logic [13:0] MAX_CNT = 14'(MAX_BITS);
   localparam logic [7:0]  LAT_CNT = 8'(CHECK_LAT);

   state_t      state;
   state_t      state_nxt;
   logic [13:0] bit_count_q;
   logic        len_err_q;
   logic [7:0]  wait_cnt;

   logic accept;
   logic saturated;
   logic verdict_pass;
   logic length_bad;
   logic count_clr;
   logic count_inc;
   logic len_set;
   logic wait_load;
   logic wait_dec;

   assign accept       = rx_bit_valid & ~bit_stuff_st;
   assign saturated    = (bit_count_q == MAX_CNT);
   assign length_bad   = (bit_count_q < 14'd16) || (bit_count_q[2:0] != 3'd0);
   assign verdict_pass = (crc_value == RESIDUAL) && !length_bad && !len_err_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      crc_clear        = 1'b0;
      crc_shift_enable = 1'b0;
      crc_serial_in    = 1'b0;
      crc_eop          = 1'b0;
      crc_ok           = 1'b0;
      crc_err          = 1'b0;
      count_clr        = 1'b0;
      count_inc        = 1'b0;
      len_set          = 1'b0;
      wait_load        = 1'b0;
      wait_dec         = 1'b0;

      case (state)
         S_IDLE: begin
            if (sop) begin
               state_nxt = S_CLEAR;
            end
         end

         S_CLEAR: begin
            crc_clear = 1'b1;
            count_clr = 1'b1;
            state_nxt = S_SHIFT;
         end

         S_SHIFT: begin
            crc_serial_in = rx_bit;
            // A new sop abandons the packet outright, so nothing else this cycle counts.
            if (sop) begin
               state_nxt = S_CLEAR;
            end else begin
               if (accept) begin
                  if (saturated) begin
                     len_set = 1'b1;
                  end else begin
                     crc_shift_enable = 1'b1;
                     count_inc        = 1'b1;
                  end
               end
               if (eop) begin
                  crc_eop = 1'b1;
                  if (CHECK_LAT == 0) begin
                     state_nxt = S_VERDICT;
                  end else begin
                     wait_load = 1'b1;
                     state_nxt = S_WAIT;
                  end
               end
            end
         end

         S_WAIT: begin
            wait_dec = 1'b1;
            if (sop) begin
               state_nxt = S_CLEAR;
            end else if (wait_cnt <= 8'd1) begin
               state_nxt = S_VERDICT;
            end
         end

         S_VERDICT: begin
            crc_ok    = verdict_pass;
            crc_err   = ~verdict_pass;
            len_set   = length_bad;
            state_nxt = sop ? S_CLEAR : S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_count_q <= 14'd0;
         len_err_q   <= 1'b0;
         wait_cnt    <= 8'd0;
      end else begin
         if (count_clr) begin
            bit_count_q <= 14'd0;
         end else if (count_inc) begin
            bit_count_q <= bit_count_q + 14'd1;
         end

         if (count_clr) begin
            len_err_q <= 1'b0;
         end else if (len_set) begin
            len_err_q <= 1'b1;
         end

         if (wait_load) begin
            wait_cnt <= LAT_CNT;
         end else if (wait_dec && (wait_cnt != 8'd0)) begin
            wait_cnt <= wait_cnt - 8'd1;
         end
      end
   end

   assign bit_count = bit_count_q;
   assign len_err   = len_err_q;
   assign busy      = (state != S_IDLE);

`ifdef CRC_RX_STATS_EN
   logic [7:0] good_q;
   logic [7:0] bad_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         good_q <= 8'd0;
         bad_q  <= 8'd0;
      end else begin
         if (crc_ok && (good_q != 8'hFF)) begin
            good_q <= good_q + 8'd1;
         end
         if (crc_err && (bad_q != 8'hFF)) begin
            bad_q <= bad_q + 8'd1;
         end
      end
   end

   assign good_pkts = good_q;
   assign bad_pkts  = bad_q;
`else
   assign good_pkts = 8'h00;
   assign bad_pkts  = 8'h00;
`endif

endmodule
